uart_tx_fifo: RTL and testbench

Parametrised, buffered UART transmitter; next generation of the single-byte PC-link transmitter.
- Accepts bytes into an internal FIFO and serialises them LSB-first.
- Data width, baud divisor, stop-bit count and FIFO depth are parameters.
- Back-to-back frames leave no idle gap.
- Sits between the command/response logic and the serial pin to the host PC.

---
 rtl/uart_tx_fifo.sv | 216 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo -- buffered, parametrised UART transmitter.
//
// Bytes are accepted into a small FIFO and serialised LSB-first as
// start bit, DATA_BITS data bits, an optional parity bit and STOP_BITS stop
// bits. Every bit lasts CLK_DIV clocks. If another byte is waiting when the
// last stop bit ends, its start bit follows immediately, with no idle gap.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after
// the data bits. parity_odd_i selects odd (1) or even (0) parity. Without
// the macro, parity_odd_i is present but ignored.
//
// Ports:
//   clk_i        system clock
//   rst_n_i      asynchronous active-low reset; aborts any frame in flight
//   tx_start_i   write strobe; tx_data_i is pushed when tx_start_i & tx_rdy_o
//   tx_data_i    byte to transmit (DATA_BITS wide)
//   parity_odd_i parity sense, sampled when a byte leaves the FIFO
//   tx_o         serial line, idles high (registered)
//   tx_rdy_o     FIFO not full
//   tx_busy_o    frame in progress or FIFO non-empty
//   fifo_cnt_o   FIFO occupancy
//   overflow_o   one-cycle pulse, the cycle after a push was dropped
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int CLK_DIV    = 2604,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        tx_start_i,
    input  logic [DATA_BITS-1:0]        tx_data_i,
    input  logic                        parity_odd_i,
    output logic                        tx_o,
    output logic                        tx_rdy_o,
    output logic                        tx_busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o,
    output logic                        overflow_o
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLK_DIV);
    // Counts data bits (up to 8) and stop bits (up to 2).
    localparam int IDX_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 ovf_q;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = parity_odd_i;
`endif

    logic fifo_empty, fifo_rdy, push, pop, bit_done, last_data, last_stop;

    // Occupancy is checked before any pop: a full FIFO refuses a push even
    // when a byte leaves it in the same cycle.
    assign fifo_empty = (cnt_q == '0);
    assign fifo_rdy   = (cnt_q != CNT_W'(FIFO_DEPTH));
    assign push       = tx_start_i & fifo_rdy;
    assign bit_done   = (baud_q == BAUD_W'(CLK_DIV - 1));
    assign last_data  = (idx_q == IDX_W'(DATA_BITS - 1));
    assign last_stop  = (idx_q == IDX_W'(STOP_BITS - 1));
    // A byte is popped exactly when a new frame begins.
    assign pop        = (state_d == S_START) && (state_q != S_START);

    // ---------------- state / datapath registers ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            baud_q   <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
            cnt_q    <= cnt_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ovf_q    <= tx_start_i & ~fifo_rdy;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // FIFO storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= tx_data_i;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!fifo_empty) state_d = S_START;
            S_START:  if (bit_done) state_d = S_DATA;
            S_DATA: begin
                if (bit_done && last_data) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_done) state_d = S_STOP;
`endif
            S_STOP: begin
                if (bit_done && last_stop) begin
                    state_d = fifo_empty ? S_IDLE : S_START;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        tx_d    = tx_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        // Baud counter rests at zero in IDLE, so a new frame starts aligned.
        baud_d  = (state_q == S_IDLE || bit_done) ? '0 : baud_q + 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        if (pop) begin
            tx_d    = 1'b0;
            shift_d = mem[rd_ptr_q];
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            par_d   = (^mem[rd_ptr_q]) ^ parity_odd_i;
`endif
        end else if (bit_done) begin
            case (state_q)
                S_START: tx_d = shift_q[0];
                S_DATA: begin
                    if (last_data) begin
                        idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        tx_d  = par_q;
`else
                        tx_d  = 1'b1;
`endif
                    end else begin
                        // shift_q[1] is the bit that moves into position 0.
                        tx_d    = shift_q[1];
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    tx_d  = 1'b1;
                    idx_d = '0;
                end
`endif
                S_STOP: begin
                    tx_d  = 1'b1;
                    idx_d = idx_q + 1'b1;
                end
                default: tx_d = 1'b1;
            endcase
        end
    end

    assign tx_o       = tx_q;
    assign tx_rdy_o   = fifo_rdy;
    assign tx_busy_o  = (state_q != S_IDLE) || !fifo_empty;
    assign fifo_cnt_o = cnt_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int CD    = 16;
    localparam int DW    = 8;
    localparam int SB    = 1;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB  = 1 + DW + P + SB;   // bits per frame, main instance
    localparam int NB2 = 1 + 7 + P + 2;     // bits per frame, 7-data/2-stop instance

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       parity_odd = 1'b0;
    logic       tx, tx_rdy, tx_busy, overflow;
    logic [2:0] fifo_cnt;

    logic       c_start = 1'b0;
    logic [6:0] c_data = 7'h00;
    logic       c_podd = 1'b0;
    logic       c_tx, c_rdy, c_busy, c_ovf;
    logic [2:0] c_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(DW), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .tx_start_i(tx_start), .tx_data_i(tx_data),
        .parity_odd_i(parity_odd), .tx_o(tx), .tx_rdy_o(tx_rdy), .tx_busy_o(tx_busy),
        .fifo_cnt_o(fifo_cnt), .overflow_o(overflow)
    );

    uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_cfg (
        .clk_i(clk), .rst_n_i(rst_n), .tx_start_i(c_start), .tx_data_i(c_data),
        .parity_odd_i(c_podd), .tx_o(c_tx), .tx_rdy_o(c_rdy), .tx_busy_o(c_busy),
        .fifo_cnt_o(c_cnt), .overflow_o(c_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The line is a sequence of frames; each frame is a list of bit values,
    // each held for CD cycles. Waiting bytes sit in a queue of at most DEPTH.
    logic [7:0] m_q[$];
    bit         m_frame [0:15];
    bit         m_active = 1'b0;
    int         m_k = 0;
    bit         m_ovf = 1'b0;

    initial begin : model
        bit         accept;
        logic [7:0] d;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_active = 1'b0;
                m_k      = 0;
                m_ovf    = 1'b0;
            end else begin
                accept = tx_start && (m_q.size() < DEPTH);
                m_ovf  = tx_start && !(m_q.size() < DEPTH);
                if (m_active) begin
                    m_k++;
                    if (m_k == NB * CD) m_active = 1'b0;
                end
                if (!m_active && m_q.size() != 0) begin
                    d = m_q.pop_front();
                    m_frame[0] = 1'b0;
                    for (int i = 0; i < DW; i++) m_frame[1 + i] = d[i];
                    if (P == 1) m_frame[1 + DW] = (^d) ^ parity_odd;
                    for (int s = 0; s < SB; s++) m_frame[1 + DW + P + s] = 1'b1;
                    m_active = 1'b1;
                    m_k      = 0;
                end
                if (accept) m_q.push_back(tx_data);
            end
        end
    end

    // Cycle-by-cycle comparison of every output of the main instance.
    initial begin : monitor
        logic [6:0] exp_v, act_v;
        bit         exp_tx;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_tx = m_active ? m_frame[m_k / CD] : 1'b1;
            exp_v  = {exp_tx, (m_q.size() < DEPTH) ? 1'b1 : 1'b0,
                      (m_active || m_q.size() != 0) ? 1'b1 : 1'b0,
                      3'(m_q.size()), m_ovf};
            act_v  = {tx, tx_rdy, tx_busy, fifo_cnt, overflow};
            check("scoreboard{tx,rdy,busy,cnt,ovf}", act_v, exp_v);
        end
    end

    initial begin : watchdog
        #(90000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wait_idle();
        int n = 0;
        while ((tx_busy || c_busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", {tx_busy, c_busy}, 2'b00);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       podd;
        logic       exp_par;
    } vec_t;

    vec_t vecs [7];

    // Push one byte into an idle transmitter and decode the frame at mid-bit.
    task automatic send_vec(input int idx, input vec_t v);
        bit         got [0:15];
        logic [7:0] d;
        @(negedge clk);
        tx_start = 1'b1; tx_data = v.data; parity_odd = v.podd;
        @(negedge clk);
        tx_start = 1'b0;
        check($sformatf("vec%0d_pre_start", idx), tx, 1'b1);
        @(negedge clk);
        check($sformatf("vec%0d_start_latency", idx), tx, 1'b0);
        for (int n = 1; n <= NB * CD; n++) begin
            @(negedge clk);
            if (n % CD == CD / 2) got[n / CD] = tx;
            if (n == NB * CD - 1) check($sformatf("vec%0d_busy_hold", idx), tx_busy, 1'b1);
            if (n == NB * CD)     check($sformatf("vec%0d_busy_fall", idx), tx_busy, 1'b0);
        end
        for (int i = 0; i < DW; i++) d[i] = got[1 + i];
        check($sformatf("vec%0d_start_bit", idx), got[0], 1'b0);
        check($sformatf("vec%0d_data", idx), d, v.data);
        if (P == 1) check($sformatf("vec%0d_parity", idx), got[1 + DW], v.exp_par);
        for (int s = 0; s < SB; s++)
            check($sformatf("vec%0d_stop", idx), got[1 + DW + P + s], 1'b1);
    endtask

    initial begin : main
        int lows, highs, ovf_seen, quiet;
        int pct;

        // Parity bits are hand-derived: ones count of data XOR podd.
        vecs[0] = '{8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b0, 1'b1};
        vecs[2] = '{8'h07, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1};
        vecs[5] = '{8'h3C, 1'b1, 1'b1};
        vecs[6] = '{8'h80, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_outputs", {tx, tx_rdy, tx_busy, fifo_cnt, overflow}, 7'b1_1_0_000_0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            wait_idle();
            send_vec(i, vecs[i]);
        end

        // Back-to-back: three frames without an idle cycle between them.
        wait_idle();
        parity_odd = 1'b0;
        @(negedge clk); tx_start = 1'b1; tx_data = 8'h00;
        @(negedge clk); check("b2b_cnt_1", fifo_cnt, 3'd1); tx_data = 8'hFF;
        @(negedge clk); check("b2b_cnt_2", fifo_cnt, 3'd1); check("b2b_first_start", tx, 1'b0);
        tx_data = 8'h3C;
        @(negedge clk); tx_start = 1'b0; check("b2b_cnt_3", fifo_cnt, 3'd2);
        for (int n = 2; n <= 3 * NB * CD; n++) begin
            @(negedge clk);
            if (n == NB * CD)         check("b2b_gap_1", tx, 1'b0);
            if (n == 2 * NB * CD)     check("b2b_gap_2", tx, 1'b0);
            if (n == 3 * NB * CD - 1) check("b2b_busy_hold", tx_busy, 1'b1);
            if (n == 3 * NB * CD)     check("b2b_busy_fall", tx_busy, 1'b0);
        end

        // Overflow: six pushes on consecutive cycles into a depth-4 FIFO.
        wait_idle();
        ovf_seen = 0;
        @(negedge clk); tx_start = 1'b1; tx_data = 8'h11;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            ovf_seen += overflow;
            tx_data = 8'h11 * (i + 1);
            if (i == 5) check("ovf_full_rdy", tx_rdy, 1'b0);
        end
        @(negedge clk); tx_start = 1'b0;
        check("ovf_pulse", overflow, 1'b1);
        ovf_seen += overflow;
        @(negedge clk); check("ovf_pulse_end", overflow, 1'b0);
        for (int n = 6; n <= 5 * NB * CD; n++) begin
            @(negedge clk);
            ovf_seen += overflow;
            if (n % (NB * CD) == 0 && n < 5 * NB * CD) check("ovf_frame_start", tx, 1'b0);
            if (n == 5 * NB * CD - 1) check("ovf_busy_hold", tx_busy, 1'b1);
            if (n == 5 * NB * CD)     check("ovf_five_frames", tx_busy, 1'b0);
        end
        check("ovf_single_pulse", ovf_seen, 1);

        // 7 data bits, 2 stop bits: 0x7F gives one low bit then all high.
        wait_idle();
        lows = 0; highs = 0;
        @(negedge clk); c_start = 1'b1; c_data = 7'h7F; c_podd = 1'b0;
        @(negedge clk); c_start = 1'b0; check("cfg_pre_start", c_tx, 1'b1);
        @(negedge clk); check("cfg_start_latency", c_tx, 1'b0);
        for (int n = 1; n <= NB2 * CD; n++) begin
            @(negedge clk);
            if (n < CD) lows += (c_tx == 1'b0);
            else if (n < NB2 * CD) highs += c_tx;
            if (n == NB2 * CD - 1) check("cfg_busy_hold", c_busy, 1'b1);
            if (n == NB2 * CD)     check("cfg_busy_fall", c_busy, 1'b0);
        end
        check("cfg_start_len", lows, CD - 1);
        check("cfg_high_len", highs, (NB2 - 1) * CD);

        // Reset during data bit 3 with two bytes still queued.
        wait_idle();
        @(negedge clk); tx_start = 1'b1; tx_data = 8'h55;
        @(negedge clk); tx_data = 8'h66;
        @(negedge clk); tx_data = 8'h77;
        @(negedge clk); tx_start = 1'b0; check("rst_pre_cnt", fifo_cnt, 3'd2);
        repeat (4 * CD + 2) @(negedge clk);
        check("rst_pre_tx_low", tx, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("rst_async_outputs", {tx, tx_rdy, tx_busy, fifo_cnt, overflow}, 7'b1_1_0_000_0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int n = 0; n < 3 * NB * CD; n++) begin
            @(negedge clk);
            quiet += (tx == 1'b1 && tx_busy == 1'b0);
        end
        check("rst_nothing_sent", quiet, 3 * NB * CD);

        // Randomised traffic: a sparse phase, then a dense phase that overflows.
        for (int n = 0; n < 3000; n++) begin
            pct = (n < 2400) ? 3 : 60;
            @(negedge clk);
            tx_start   = ($urandom_range(0, 99) < pct);
            tx_data    = 8'($urandom());
            parity_odd = 1'($urandom());
        end
        @(negedge clk); tx_start = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
